// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
//
// Purpose: groups the request/result signals of the bit-serial adder
// sequencer so the controller and its client share one bundle.
//
// Signals:
//   start  - request pulse from the client
//   a, b   - WIDTH-bit operands, captured on an accepted start
//   sub    - subtract select (only when SERIAL_ADDER_SUB_EN is defined)
//   busy   - high while the adder is shifting
//   done   - one-cycle completion pulse
//   sum    - registered WIDTH-bit result
//   c_out  - registered final carry (no-borrow flag when subtracting)
//
// Modports: master (client side), slave (controller side).
// Optional feature macro: SERIAL_ADDER_SUB_EN
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, c_out);
  modport slave  (input start, a, b, sub, output busy, done, sum, c_out);
`else
  modport master (output start, a, b, input busy, done, sum, c_out);
  modport slave  (input start, a, b, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Purpose: bit-serial adder sequencer. Captures two WIDTH-bit operands and
// pushes them LSB first through a single full-adder cell (two half adders
// plus an OR for the carry merge), one bit per clock, for WIDTH cycles.
// The result and final carry are registered at the end of the run and held
// until the next run completes or reset.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - serial_adder_ctrl_if.slave (start, a, b, [sub], busy, done,
//          sum, c_out)
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, bus.sub=1 loads ~b and a carry-in of 1, giving a - b;
//   c_out=1 then means "no borrow". When undefined no inverter is built.
// ---------------------------------------------------------------------------

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module or_gate (
  input  logic x,
  input  logic y,
  output logic z
);
  assign z = x | y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg,  a_sh_next;
  logic [WIDTH-1:0] b_sh_reg,  b_sh_next;
  logic [WIDTH-1:0] r_sh_reg,  r_sh_next;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [WIDTH-1:0] sum_reg,   sum_next;
  logic             c_out_reg, c_out_next;

  // Operand B as loaded into its shift register, and the initial carry.
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B bitwise and inject a carry-in of 1.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
    assign b_load[gi] = bus.b[gi] ^ bus.sub;
  end
  assign carry_init = bus.sub;
`else
  assign b_load     = bus.b;
  assign carry_init = 1'b0;
`endif

  // Full-adder cell built from the gate library.
  logic ha0_s, ha0_c, cell_s, ha1_c, cell_c;

  half_adder u_ha0 (.x(a_sh_reg[0]), .y(b_sh_reg[0]), .s(ha0_s),  .c(ha0_c));
  half_adder u_ha1 (.x(ha0_s),       .y(carry_reg),   .s(cell_s), .c(ha1_c));
  or_gate    u_or  (.x(ha0_c),       .y(ha1_c),       .z(cell_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      r_sh_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      r_sh_reg  <= r_sh_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      sum_reg   <= sum_next;
      c_out_reg <= c_out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    r_sh_next  = r_sh_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_reg;
    c_out_next = c_out_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_next  = bus.a;
          b_sh_next  = b_load;
          carry_next = carry_init;
          cnt_next   = '0;
          state_next = RUN;
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end

      RUN: begin
        a_sh_next  = {1'b0, a_sh_reg[WIDTH-1:1]};
        b_sh_next  = {1'b0, b_sh_reg[WIDTH-1:1]};
        r_sh_next  = {cell_s, r_sh_reg[WIDTH-1:1]};
        carry_next = cell_c;
        if (cnt_reg == CNT_LAST) begin
          // Last bit: publish the fully shifted result. The counter is
          // held rather than incremented so it never wraps.
          sum_next   = {cell_s, r_sh_reg[WIDTH-1:1]};
          c_out_next = cell_c;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Outputs are decodes of registered state only; no input reaches them
  // combinationally.
  assign bus.busy  = (state_reg == RUN);
  assign bus.done  = (state_reg == DONE);
  assign bus.sum   = sum_reg;
  assign bus.c_out = c_out_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Purpose: self-checking bench for serial_adder_ctrl at WIDTH=8. Expected
// results are computed by a reference model when stimulus is driven, queued,
// and compared when the controller signals done.
// Optional feature macro: SERIAL_ADDER_SUB_EN (enables the subtract tests).
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic sub_sel;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

`ifdef SERIAL_ADDER_SUB_EN
  assign bus.sub = sub_sel;
`endif

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  // Reference: 9-bit {carry, sum} of a + b, or a + ~b + 1 when subtracting.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic s);
    logic [7:0] yi;
    yi = ~y;
    if (s) return {1'b0, x} + {1'b0, yi} + 9'd1;
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic drive(input logic st, input logic [7:0] x, input logic [7:0] y,
                       input logic s);
    bus.start = st;
    bus.a     = x;
    bus.b     = y;
    sub_sel   = s;
  endtask

  // Counts negedges while busy is high; bounded so a stuck DUT cannot hang.
  task automatic wait_busy_end(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.c_out, bus.sum} !== 11'b0)
        begin errors++; $display("FAIL reset_outputs cyc=%0d got busy=%b done=%b c_out=%b sum=%h want all 0",
                                 i, bus.busy, bus.done, bus.c_out, bus.sum); end
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL reset_no_run got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    $display("reset: outputs cleared, no RUN entry");
  endtask

  task automatic test_basic_add();
    int n;
    logic [8:0] e;
    drive(1'b1, 8'h35, 8'h4A, 1'b0);
    exp_q.push_back(model(8'h35, 8'h4A, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0)
      begin errors++; $display("FAIL add_busy_rise got busy=%b done=%b want 1 0", bus.busy, bus.done); end
    wait_busy_end(n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL add_busy_len got %0d want 8", n); end
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL add_done got %b want 1", bus.done); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL add_queue empty want 1 entry"); end
    else begin
      e = exp_q.pop_front();
      if ({bus.c_out, bus.sum} !== e)
        begin errors++; $display("FAIL add_result got c_out=%b sum=%h want c_out=%b sum=%h",
                                 bus.c_out, bus.sum, e[8], e[7:0]); end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b want 0", bus.done); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.sum !== 8'h7F || bus.c_out !== 1'b0)
      begin errors++; $display("FAIL add_hold got c_out=%b sum=%h want 0 7f", bus.c_out, bus.sum); end
    $display("basic_add: 35+4a sum=%h c_out=%b", bus.sum, bus.c_out);
  endtask

  task automatic test_carry_out();
    logic [7:0] ta [2] = '{8'hFF, 8'h80};
    logic [7:0] tb [2] = '{8'h01, 8'h80};
    int n;
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, ta[i], tb[i], 1'b0);
      exp_q.push_back(model(ta[i], tb[i], 1'b0));
      @(negedge clk);
      bus.start = 1'b0;
      wait_busy_end(n);
      checks++;
      if (n !== 8 || bus.done !== 1'b1)
        begin errors++; $display("FAIL carry_timing case=%0d got len=%0d done=%b want 8 1", i, n, bus.done); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL carry_queue empty case=%0d", i); end
      else begin
        e = exp_q.pop_front();
        if ({bus.c_out, bus.sum} !== e)
          begin errors++; $display("FAIL carry_result case=%0d got c_out=%b sum=%h want c_out=%b sum=%h",
                                   i, bus.c_out, bus.sum, e[8], e[7:0]); end
      end
      $display("carry_out: %h+%h sum=%h c_out=%b", ta[i], tb[i], bus.sum, bus.c_out);
      @(negedge clk);
    end
  endtask

  task automatic test_handshake();
    int n;
    logic [8:0] e;
    drive(1'b1, 8'h01, 8'h02, 1'b0);
    exp_q.push_back(model(8'h01, 8'h02, 1'b0));
    @(negedge clk);
    // start stays high; these operands must be ignored until DONE
    drive(1'b1, 8'hAA, 8'h55, 1'b0);
    exp_q.push_back(model(8'hAA, 8'h55, 1'b0));
    wait_busy_end(n);
    checks++;
    if (n !== 8 || bus.done !== 1'b1)
      begin errors++; $display("FAIL hs_first_timing got len=%0d done=%b want 8 1", n, bus.done); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL hs_queue empty first"); end
    else begin
      e = exp_q.pop_front();
      if ({bus.c_out, bus.sum} !== e)
        begin errors++; $display("FAIL hs_first_result got c_out=%b sum=%h want c_out=%b sum=%h",
                                 bus.c_out, bus.sum, e[8], e[7:0]); end
    end
    $display("handshake: first op sum=%h c_out=%b", bus.sum, bus.c_out);
    // start still high in DONE: next edge (9 after the first) starts op 2
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0)
      begin errors++; $display("FAIL hs_restart got busy=%b done=%b want 1 0", bus.busy, bus.done); end
    checks++;
    if (bus.sum !== 8'h03)
      begin errors++; $display("FAIL hs_hold_in_run got sum=%h want 03", bus.sum); end
    wait_busy_end(n);
    checks++;
    if (n !== 8 || bus.done !== 1'b1)
      begin errors++; $display("FAIL hs_second_timing got len=%0d done=%b want 8 1", n, bus.done); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL hs_queue empty second"); end
    else begin
      e = exp_q.pop_front();
      if ({bus.c_out, bus.sum} !== e)
        begin errors++; $display("FAIL hs_second_result got c_out=%b sum=%h want c_out=%b sum=%h",
                                 bus.c_out, bus.sum, e[8], e[7:0]); end
    end
    $display("handshake: second op sum=%h c_out=%b", bus.sum, bus.c_out);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic [8:0] e;
    logic saw_done;
    drive(1'b1, 8'h10, 8'h20, 1'b0);
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;                      // 4th RUN cycle
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.c_out, bus.sum} !== 11'b0)
      begin errors++; $display("FAIL midrst_outputs got busy=%b done=%b c_out=%b sum=%h want all 0",
                               bus.busy, bus.done, bus.c_out, bus.sum); end
    void'(exp_q.pop_back());         // aborted operation produces nothing
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got activity=1 want 0"); end
    $display("reset_mid_run: aborted, outputs cleared");
    drive(1'b1, 8'h10, 8'h20, 1'b0);
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    wait_busy_end(n);
    checks++;
    if (n !== 8 || bus.done !== 1'b1)
      begin errors++; $display("FAIL midrst_restart_timing got len=%0d done=%b want 8 1", n, bus.done); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL midrst_queue empty"); end
    else begin
      e = exp_q.pop_front();
      if ({bus.c_out, bus.sum} !== e)
        begin errors++; $display("FAIL midrst_restart_result got c_out=%b sum=%h want c_out=%b sum=%h",
                                 bus.c_out, bus.sum, e[8], e[7:0]); end
    end
    $display("reset_mid_run: restart 10+20 sum=%h", bus.sum);
    @(negedge clk);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] ta [3] = '{8'h05, 8'h03, 8'h05};
    logic [7:0] tb [3] = '{8'h03, 8'h05, 8'h03};
    logic       ts [3] = '{1'b1, 1'b1, 1'b0};
    int n;
    logic [8:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ta[i], tb[i], ts[i]);
      exp_q.push_back(model(ta[i], tb[i], ts[i]));
      @(negedge clk);
      bus.start = 1'b0;
      wait_busy_end(n);
      checks++;
      if (n !== 8 || bus.done !== 1'b1)
        begin errors++; $display("FAIL sub_timing case=%0d got len=%0d done=%b want 8 1", i, n, bus.done); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL sub_queue empty case=%0d", i); end
      else begin
        e = exp_q.pop_front();
        if ({bus.c_out, bus.sum} !== e)
          begin errors++; $display("FAIL sub_result case=%0d got c_out=%b sum=%h want c_out=%b sum=%h",
                                   i, bus.c_out, bus.sum, e[8], e[7:0]); end
      end
      $display("sub: %h %s %h sum=%h c_out=%b", ta[i], ts[i] ? "-" : "+", tb[i], bus.sum, bus.c_out);
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    test_reset();
    test_basic_add();
    test_carry_out();
    test_handshake();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
